// File: rtl/exception_sequencer.sv
// exception_sequencer: multicycle exception entry sequencer feeding the exception-vector mux.
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-low reset
//   excp_opcode   in   invalid opcode flag (1-cycle pulse)
//   excp_overflow in   ALU overflow flag (1-cycle pulse)
//   excp_div0     in   divide-by-zero flag (1-cycle pulse)
//   pc_in         in   current PC value
//   mem_data_in   in   memory read word, handler byte in [31:24]
//   excpt_ctrl    out  vector select: 00 opcode, 01 overflow, 10 div0
//   addr_sel_excp out  steer memory address to vector mux
//   epc_write     out  EPC write enable
//   epc_data      out  pc_in - EPC_OFFSET
//   pc_write      out  PC write enable
//   pc_data       out  zero-extended handler byte
//   busy          out  sequencing in progress
//   cause         out  code of last taken exception
module exception_sequencer #(
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] EPC_OFFSET  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_opcode,
    input  logic        excp_overflow,
    input  logic        excp_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [1:0]  excpt_ctrl,
    output logic        addr_sel_excp,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        pc_write,
    output logic [31:0] pc_data,
    output logic        busy,
    output logic [1:0]  cause
);
    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_WAIT, S_LOAD} state_t;
    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] cause_q, cause_d;
    logic [1:0] cnt_q, cnt_d;
    logic       any_flag;
    logic [1:0] win;
    logic       unused_mem;
    assign any_flag   = excp_opcode | excp_overflow | excp_div0;
    assign win        = excp_div0 ? 2'b10 : excp_overflow ? 2'b01 : 2'b00;
    assign unused_mem = ^mem_data_in[23:0];
    assign cause      = cause_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sel_q   <= 2'b00;
            cause_q <= 2'b00;
            cnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end
    // Flags are only looked at in IDLE, so anything arriving while busy is dropped.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (any_flag) begin
                state_d = S_SAVE;
                sel_d   = win;
                cause_d = win;
            end
            S_SAVE: begin
                state_d = S_WAIT;
                cnt_d   = 2'(MEM_LATENCY - 1);
            end
            S_WAIT: if (cnt_q == 2'd0) state_d = S_LOAD;
                    else cnt_d = cnt_q - 2'd1;
            default: state_d = S_IDLE;
        endcase
    end
    always_comb begin
        busy          = state_q != S_IDLE;
        addr_sel_excp = busy;
        excpt_ctrl    = busy ? sel_q : 2'b00;
        epc_write     = state_q == S_SAVE;
        epc_data      = epc_write ? pc_in - EPC_OFFSET : 32'd0;
        pc_write      = state_q == S_LOAD;
        pc_data       = pc_write ? {24'd0, mem_data_in[31:24]} : 32'd0;
    end
endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer: directed checks of exception_sequencer at MEM_LATENCY 1 and 3.
module tb_exception_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst1, op1, ov1, dz1, rst3, op3, ov3, dz3;
    logic [31:0] pc, mem;
    logic [1:0]  ctrl1, cause1, ctrl3, cause3;
    logic        as1, ew1, pw1, busy1, as3, ew3, pw3, busy3;
    logic [31:0] ed1, pd1, ed3, pd3;
    int          n_run = 0, n_fail = 0;

    exception_sequencer #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst1), .excp_opcode(op1), .excp_overflow(ov1), .excp_div0(dz1),
        .pc_in(pc), .mem_data_in(mem), .excpt_ctrl(ctrl1), .addr_sel_excp(as1),
        .epc_write(ew1), .epc_data(ed1), .pc_write(pw1), .pc_data(pd1), .busy(busy1), .cause(cause1));
    exception_sequencer #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(rst3), .excp_opcode(op3), .excp_overflow(ov3), .excp_div0(dz3),
        .pc_in(pc), .mem_data_in(mem), .excpt_ctrl(ctrl3), .addr_sel_excp(as3),
        .epc_write(ew3), .epc_data(ed3), .pc_write(pw3), .pc_data(pd3), .busy(busy3), .cause(cause3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe snapshot: busy, epc_write, pc_write, addr_sel_excp, excpt_ctrl, cause.
    task automatic snap1(input string t, input logic b, input logic e, input logic p,
                         input logic a, input logic [1:0] c, input logic [1:0] k);
        chk({t, ".busy"}, 32'(busy1), 32'(b));
        chk({t, ".epcw"}, 32'(ew1), 32'(e));
        chk({t, ".pcw"}, 32'(pw1), 32'(p));
        chk({t, ".asel"}, 32'(as1), 32'(a));
        chk({t, ".ctrl"}, 32'(ctrl1), 32'(c));
        chk({t, ".cause"}, 32'(cause1), 32'(k));
    endtask

    task automatic snap3(input string t, input logic b, input logic e, input logic p,
                         input logic a, input logic [1:0] c, input logic [1:0] k);
        chk({t, ".busy"}, 32'(busy3), 32'(b));
        chk({t, ".epcw"}, 32'(ew3), 32'(e));
        chk({t, ".pcw"}, 32'(pw3), 32'(p));
        chk({t, ".asel"}, 32'(as3), 32'(a));
        chk({t, ".ctrl"}, 32'(ctrl3), 32'(c));
        chk({t, ".cause"}, 32'(cause3), 32'(k));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst1 = 1'b0; rst3 = 1'b0;
        op1 = 0; ov1 = 0; dz1 = 1; op3 = 0; ov3 = 0; dz3 = 1;
        pc = 32'h0000_0108; mem = 32'hA012_3456;
        tick(); tick();
        snap1("rst1", 0, 0, 0, 0, 2'b00, 2'b00);
        chk("rst1.epcd", ed1, 32'd0);
        chk("rst1.pcd", pd1, 32'd0);
        snap3("rst3", 0, 0, 0, 0, 2'b00, 2'b00);
        dz1 = 0; dz3 = 0; rst1 = 1; rst3 = 1;
        tick();
        snap1("postrst", 0, 0, 0, 0, 2'b00, 2'b00);

        // Overflow, latency 1
        ov1 = 1;
        tick(); ov1 = 0;
        snap1("ov.save", 1, 1, 0, 1, 2'b01, 2'b01);
        chk("ov.epcd", ed1, 32'h0000_0104);
        tick();
        snap1("ov.wait", 1, 0, 0, 1, 2'b01, 2'b01);
        tick();
        snap1("ov.load", 1, 0, 1, 1, 2'b01, 2'b01);
        chk("ov.pcd", pd1, 32'h0000_00A0);
        tick();
        snap1("ov.idle", 0, 0, 0, 0, 2'b00, 2'b01);

        // Simultaneous flags: div0 wins
        op1 = 1; ov1 = 1; dz1 = 1; mem = 32'h3300_0000;
        tick(); op1 = 0; ov1 = 0; dz1 = 0;
        snap1("all.save", 1, 1, 0, 1, 2'b10, 2'b10);
        tick();
        snap1("all.wait", 1, 0, 0, 1, 2'b10, 2'b10);
        tick();
        snap1("all.load", 1, 0, 1, 1, 2'b10, 2'b10);
        chk("all.pcd", pd1, 32'h0000_0033);
        // Flag in the cycle the sequencer returns to IDLE is taken; also EPC wrap
        tick();
        snap1("all.idle", 0, 0, 0, 0, 2'b00, 2'b10);
        op1 = 1; pc = 32'h0000_0002;
        tick(); op1 = 0;
        snap1("wrap.save", 1, 1, 0, 1, 2'b00, 2'b00);
        chk("wrap.epcd", ed1, 32'hFFFF_FFFE);
        tick(); tick(); tick();
        snap1("wrap.idle", 0, 0, 0, 0, 2'b00, 2'b00);

        // Latency 3 with overflow during WAIT ignored
        pc = 32'h0000_0200; mem = 32'h7700_0000;
        op3 = 1;
        tick(); op3 = 0;
        snap3("l3.save", 1, 1, 0, 1, 2'b00, 2'b00);
        chk("l3.epcd", ed3, 32'h0000_01FC);
        tick(); ov3 = 1;
        snap3("l3.wait1", 1, 0, 0, 1, 2'b00, 2'b00);
        tick(); ov3 = 0;
        snap3("l3.wait2", 1, 0, 0, 1, 2'b00, 2'b00);
        tick();
        snap3("l3.wait3", 1, 0, 0, 1, 2'b00, 2'b00);
        tick();
        snap3("l3.load", 1, 0, 1, 1, 2'b00, 2'b00);
        chk("l3.pcd", pd3, 32'h0000_0077);
        tick();
        snap3("l3.idle", 0, 0, 0, 0, 2'b00, 2'b00);
        tick();
        snap3("l3.idle2", 0, 0, 0, 0, 2'b00, 2'b00);

        // Reset during WAIT aborts, then div0 handled normally
        ov3 = 1;
        tick(); ov3 = 0;
        snap3("ab.save", 1, 1, 0, 1, 2'b01, 2'b01);
        tick(); rst3 = 0;
        snap3("ab.wait", 1, 0, 0, 1, 2'b01, 2'b01);
        tick(); rst3 = 1;
        snap3("ab.rst", 0, 0, 0, 0, 2'b00, 2'b00);
        tick();
        snap3("ab.idle", 0, 0, 0, 0, 2'b00, 2'b00);
        dz3 = 1;
        tick(); dz3 = 0;
        snap3("dz.save", 1, 1, 0, 1, 2'b10, 2'b10);
        tick(); tick(); tick();
        snap3("dz.wait3", 1, 0, 0, 1, 2'b10, 2'b10);
        tick();
        snap3("dz.load", 1, 0, 1, 1, 2'b10, 2'b10);
        tick();
        snap3("dz.idle", 0, 0, 0, 0, 2'b00, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
